// File: rtl/axil_csr_pkg.sv
// Shared constants for the AXI4-Lite CSR slave.
//   RESP_OKAY / RESP_SLVERR : AXI response encodings
//   REG_ID / REG_SCRATCH    : well-known register indices
//   ID_VALUE_DEFAULT        : default contents of the read-only ID register
package axil_csr_pkg;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [1:0]  RESP_SLVERR      = 2'b10;

  localparam int          REG_ID           = 0;
  localparam int          REG_SCRATCH      = 1;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'h5244_4D41;

endpackage

// File: rtl/axil_csr_slave.sv
// AXI4-Lite slave exposing a bank of 32-bit control/status registers.
// Reg 0 is a read-only ID; regs 1..NUM_REGS-1 are read/write with byte strobes.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   S_AXI_LITE_aw*/w*/b*       : write address / data / response channels
//   S_AXI_LITE_ar*/r*          : read address / data channels
//   reg_out                    : flat register contents, reg i at [32i+31:32i]
//   reg_wr_pulse               : one-cycle strobe per committed register write
// One outstanding write and one outstanding read; the channels run independently.
module axil_csr_slave
  import axil_csr_pkg::*;
#(
  parameter int          NUM_REGS   = 16,
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] ID_VALUE   = ID_VALUE_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_LITE_awaddr,
  input  logic [2:0]              S_AXI_LITE_awprot,
  input  logic                    S_AXI_LITE_awvalid,
  output logic                    S_AXI_LITE_awready,
  input  logic [31:0]             S_AXI_LITE_wdata,
  input  logic [3:0]              S_AXI_LITE_wstrb,
  input  logic                    S_AXI_LITE_wvalid,
  output logic                    S_AXI_LITE_wready,
  output logic [1:0]              S_AXI_LITE_bresp,
  output logic                    S_AXI_LITE_bvalid,
  input  logic                    S_AXI_LITE_bready,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_LITE_araddr,
  input  logic [2:0]              S_AXI_LITE_arprot,
  input  logic                    S_AXI_LITE_arvalid,
  output logic                    S_AXI_LITE_arready,
  output logic [31:0]             S_AXI_LITE_rdata,
  output logic [1:0]              S_AXI_LITE_rresp,
  output logic                    S_AXI_LITE_rvalid,
  input  logic                    S_AXI_LITE_rready,
  output logic [NUM_REGS*32-1:0]  reg_out,
  output logic [NUM_REGS-1:0]     reg_wr_pulse
);

  localparam int IDX_W = $clog2(NUM_REGS);

  // Any address bit above the register index field marks an access as out of range.
  function automatic logic addr_oob(input logic [ADDR_WIDTH-1:0] a);
    return (a >> (IDX_W + 2)) != '0;
  endfunction

  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [31:0]           w_data_q;
  logic [3:0]            w_strb_q;
  logic [31:0]           regs [NUM_REGS];
  logic [31:0]           view [NUM_REGS];

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic                  wr_oob, rd_oob;

  assign S_AXI_LITE_awready = !reset && !aw_held && !S_AXI_LITE_bvalid;
  assign S_AXI_LITE_wready  = !reset && !w_held  && !S_AXI_LITE_bvalid;
  assign S_AXI_LITE_arready = !reset && !S_AXI_LITE_rvalid;

  always_comb begin
    aw_hs   = S_AXI_LITE_awvalid && S_AXI_LITE_awready;
    w_hs    = S_AXI_LITE_wvalid  && S_AXI_LITE_wready;
    ar_hs   = S_AXI_LITE_arvalid && S_AXI_LITE_arready;
    // Commit as soon as both halves are available, whether held or arriving now.
    commit  = (aw_held || aw_hs) && (w_held || w_hs);
    wr_addr = aw_held ? aw_addr_q : S_AXI_LITE_awaddr;
    wr_data = w_held  ? w_data_q  : S_AXI_LITE_wdata;
    wr_strb = w_held  ? w_strb_q  : S_AXI_LITE_wstrb;
    wr_idx  = wr_addr[IDX_W+1:2];
    wr_oob  = addr_oob(wr_addr);
    rd_idx  = S_AXI_LITE_araddr[IDX_W+1:2];
    rd_oob  = addr_oob(S_AXI_LITE_araddr);
  end

  // Reg 0 is a constant; its storage slot is never read through the view.
  always_comb begin
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      view[k] = (k == 0) ? ID_VALUE : regs[k];
    end
    reg_out = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      reg_out[32*k +: 32] = view[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aw_held           <= 1'b0;
      w_held            <= 1'b0;
      aw_addr_q         <= '0;
      w_data_q          <= '0;
      w_strb_q          <= '0;
      S_AXI_LITE_bvalid <= 1'b0;
      S_AXI_LITE_bresp  <= RESP_OKAY;
      reg_wr_pulse      <= '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        regs[k] <= '0;
      end
    end else begin
      reg_wr_pulse <= '0;
      if (commit) begin
        aw_held           <= 1'b0;
        w_held            <= 1'b0;
        S_AXI_LITE_bvalid <= 1'b1;
        S_AXI_LITE_bresp  <= wr_oob ? RESP_SLVERR : RESP_OKAY;
        if (!wr_oob && wr_idx != IDX_W'(REG_ID)) begin
          for (int unsigned b = 0; b < 4; b++) begin
            if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
          end
          reg_wr_pulse[wr_idx] <= 1'b1;
        end
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_addr_q <= S_AXI_LITE_awaddr;
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= S_AXI_LITE_wdata;
          w_strb_q <= S_AXI_LITE_wstrb;
        end
      end
      // Readies are low while bvalid is set, so this never overlaps a commit.
      if (S_AXI_LITE_bvalid && S_AXI_LITE_bready) S_AXI_LITE_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      S_AXI_LITE_rvalid <= 1'b0;
      S_AXI_LITE_rdata  <= '0;
      S_AXI_LITE_rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      S_AXI_LITE_rvalid <= 1'b1;
      S_AXI_LITE_rdata  <= rd_oob ? '0 : view[rd_idx];
      S_AXI_LITE_rresp  <= rd_oob ? RESP_SLVERR : RESP_OKAY;
    end else if (S_AXI_LITE_rvalid && S_AXI_LITE_rready) begin
      S_AXI_LITE_rvalid <= 1'b0;
    end
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, S_AXI_LITE_awprot, S_AXI_LITE_arprot,
                         wr_addr[1:0], S_AXI_LITE_araddr[1:0]};

endmodule

// File: tb/tb_axil_csr_slave.sv
// Self-checking bench for axil_csr_slave: a table of directed transactions,
// hand-written multi-cycle sequences and randomized traffic against a register model.
module tb_axil_csr_slave;

  localparam int          NUM_REGS = 16;
  localparam int          AW       = 32;
  localparam logic [31:0] ID       = 32'h5244_4D41;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [AW-1:0]          awaddr = '0;
  logic [2:0]             awprot = '0;
  logic                   awvalid = 1'b0;
  logic                   awready;
  logic [31:0]            wdata = '0;
  logic [3:0]             wstrb = '0;
  logic                   wvalid = 1'b0;
  logic                   wready;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready = 1'b0;
  logic [AW-1:0]          araddr = '0;
  logic [2:0]             arprot = '0;
  logic                   arvalid = 1'b0;
  logic                   arready;
  logic [31:0]            rdata;
  logic [1:0]             rresp;
  logic                   rvalid;
  logic                   rready = 1'b0;
  logic [NUM_REGS*32-1:0] reg_out;
  logic [NUM_REGS-1:0]    reg_wr_pulse;

  always #5 clk = ~clk;

  axil_csr_slave #(.NUM_REGS(NUM_REGS), .ADDR_WIDTH(AW), .ID_VALUE(ID)) dut (
    .clk(clk), .reset(reset),
    .S_AXI_LITE_awaddr(awaddr), .S_AXI_LITE_awprot(awprot),
    .S_AXI_LITE_awvalid(awvalid), .S_AXI_LITE_awready(awready),
    .S_AXI_LITE_wdata(wdata), .S_AXI_LITE_wstrb(wstrb),
    .S_AXI_LITE_wvalid(wvalid), .S_AXI_LITE_wready(wready),
    .S_AXI_LITE_bresp(bresp), .S_AXI_LITE_bvalid(bvalid), .S_AXI_LITE_bready(bready),
    .S_AXI_LITE_araddr(araddr), .S_AXI_LITE_arprot(arprot),
    .S_AXI_LITE_arvalid(arvalid), .S_AXI_LITE_arready(arready),
    .S_AXI_LITE_rdata(rdata), .S_AXI_LITE_rresp(rresp),
    .S_AXI_LITE_rvalid(rvalid), .S_AXI_LITE_rready(rready),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Register model: plain array, byte merge, address range by magnitude.
  logic [31:0] m_regs [NUM_REGS];

  function automatic void m_reset();
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
    m_regs[0] = ID;
  endfunction

  function automatic logic [511:0] m_flat();
    logic [511:0] f = '0;
    for (int i = 0; i < NUM_REGS; i++) f[32*i +: 32] = m_regs[i];
    return f;
  endfunction

  function automatic void m_write(input logic [31:0] addr, input logic [31:0] data,
                                  input logic [3:0] strb, output logic [1:0] resp,
                                  output logic [15:0] pulse);
    int i;
    pulse = '0;
    if (addr >= 32'(NUM_REGS * 4)) begin
      resp = 2'b10;
    end else begin
      resp = 2'b00;
      i = int'(addr / 4);
      if (i != 0) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) m_regs[i][8*b +: 8] = data[8*b +: 8];
        pulse[i] = 1'b1;
      end
    end
  endfunction

  function automatic void m_read(input logic [31:0] addr, output logic [31:0] data,
                                 output logic [1:0] resp);
    if (addr >= 32'(NUM_REGS * 4)) begin
      data = '0;
      resp = 2'b10;
    end else begin
      data = m_regs[int'(addr / 4)];
      resp = 2'b00;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           output logic [1:0] resp, output logic [15:0] pulse, output bit ok);
    bit aw_done = 0;
    bit w_done = 0;
    bit aw_fire, w_fire;
    int cyc = 0;
    awaddr = addr;
    wdata  = data;
    wstrb  = strb;
    while (!bvalid && cyc < 30) begin
      awvalid = !aw_done && cyc >= aw_dly;
      wvalid  = !w_done && cyc >= w_dly;
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      tick();
      if (aw_fire) aw_done = 1;
      if (w_fire) w_done = 1;
      cyc++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    ok      = bvalid;
    resp    = bresp;
    pulse   = reg_wr_pulse;
    if (ok) begin
      bready = 1'b1;
      tick();
      bready = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, input int dly,
                          output logic [31:0] data, output logic [1:0] resp, output bit ok);
    bit done = 0;
    bit fire;
    int cyc = 0;
    araddr = addr;
    while (!rvalid && cyc < 30) begin
      arvalid = !done && cyc >= dly;
      fire    = arvalid && arready;
      tick();
      if (fire) done = 1;
      cyc++;
    end
    arvalid = 1'b0;
    ok      = rvalid;
    data    = rdata;
    resp    = rresp;
    if (ok) begin
      rready = 1'b1;
      tick();
      rready = 1'b0;
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [15:0] pulse;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp, eresp;
    logic [15:0] pulse, epulse;
    logic [31:0] data, edata, old3;
    bit          ok;

    vecs[0]  = '{0, 32'h00, 32'h0,        4'h0, 2'b00, ID,           16'h0000};
    vecs[1]  = '{1, 32'h04, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0,        16'h0002};
    vecs[2]  = '{0, 32'h04, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 16'h0000};
    vecs[3]  = '{1, 32'h40, 32'h12345678, 4'hF, 2'b10, 32'h0,        16'h0000};
    vecs[4]  = '{0, 32'h40, 32'h0,        4'h0, 2'b10, 32'h0,        16'h0000};
    vecs[5]  = '{1, 32'h00, 32'h12345678, 4'hF, 2'b00, 32'h0,        16'h0000};
    vecs[6]  = '{0, 32'h00, 32'h0,        4'h0, 2'b00, ID,           16'h0000};
    vecs[7]  = '{1, 32'h07, 32'h55555555, 4'h0, 2'b00, 32'h0,        16'h0002};
    vecs[8]  = '{0, 32'h05, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 16'h0000};
    vecs[9]  = '{1, 32'h3C, 32'hAABBCCDD, 4'h8, 2'b00, 32'h0,        16'h8000};
    vecs[10] = '{0, 32'h1000_003C, 32'h0, 4'h0, 2'b10, 32'h0,        16'h0000};

    // Reset behaviour
    m_reset();
    tick();
    tick();
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_valids", {bvalid, rvalid}, 0);
    check("rst_pulse", reg_wr_pulse, 0);
    check("rst_rdata", {rdata, rresp, bresp}, 0);
    reset = 1'b0;
    tick();
    check("idle_readies", {awready, wready, arready}, 3'b111);
    check("idle_valids", {bvalid, rvalid}, 0);
    check("idle_reg_out", reg_out, m_flat());

    // Directed table
    for (int v = 0; v < 11; v++) begin
      if (vecs[v].wr) begin
        axi_write(vecs[v].addr, vecs[v].data, vecs[v].strb, 0, 0, resp, pulse, ok);
        m_write(vecs[v].addr, vecs[v].data, vecs[v].strb, eresp, epulse);
        check($sformatf("vec%0d_bvalid", v), ok, 1);
        check($sformatf("vec%0d_bresp", v), resp, vecs[v].resp);
        check($sformatf("vec%0d_pulse", v), pulse, vecs[v].pulse);
        check($sformatf("vec%0d_reg_out", v), reg_out, m_flat());
      end else begin
        axi_read(vecs[v].addr, 0, data, resp, ok);
        check($sformatf("vec%0d_rvalid", v), ok, 1);
        check($sformatf("vec%0d_rresp", v), resp, vecs[v].resp);
        check($sformatf("vec%0d_rdata", v), data, vecs[v].rdata);
      end
    end

    // W arrives three cycles before AW
    wdata  = 32'h11223344;
    wstrb  = 4'b0101;
    awaddr = 32'h08;
    wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("wfirst_wready_low", wready, 0);
      check("wfirst_no_bvalid", bvalid, 0);
      tick();
    end
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    m_write(32'h08, 32'h11223344, 4'b0101, eresp, epulse);
    check("wfirst_bvalid", {bvalid, bresp}, 3'b100);
    check("wfirst_pulse", reg_wr_pulse, 16'h0004);
    check("wfirst_reg2", reg_out[95:64], 32'h00220044);
    tick();
    check("wfirst_pulse_once", reg_wr_pulse, 0);
    check("wfirst_bvalid_hold", bvalid, 1);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("wfirst_done", {bvalid, awready, wready}, 3'b011);

    // Concurrent read and write to reg 3 under back-pressure
    m_read(32'h0C, old3, eresp);
    awaddr = 32'h0C; wdata = 32'hCAFEF00D; wstrb = 4'hF; araddr = 32'h0C;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    m_write(32'h0C, 32'hCAFEF00D, 4'hF, eresp, epulse);
    check("rw_valids", {bvalid, rvalid}, 2'b11);
    check("rw_old_rdata", rdata, old3);
    check("rw_pulse", reg_wr_pulse, 16'h0008);
    check("rw_reg_out", reg_out, m_flat());
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_valids", {bvalid, rvalid}, 2'b11);
      check("bp_data", {rdata, rresp, bresp}, {old3, 4'b0000});
      check("bp_readies", {awready, wready, arready}, 0);
    end
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    check("bp_release", {bvalid, rvalid, awready, wready, arready}, 5'b00111);

    // Reset with a held AW and a pending read response
    awaddr = 32'h04; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("rst2_aw_held", awready, 0);
    araddr = 32'h00; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check("rst2_rvalid", rvalid, 1);
    reset = 1'b1;
    tick();
    check("rst2_cleared", {bvalid, rvalid, awready, wready, arready}, 0);
    reset = 1'b0;
    m_reset();
    check("rst2_regs", reg_out, m_flat());
    wdata = 32'h99999999; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("rst2_no_commit", {bvalid, reg_wr_pulse}, 0);
      tick();
    end
    check("rst2_regs_after_w", reg_out, m_flat());
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a, d;
      logic [3:0]  s;
      a = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(6, 31));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), resp, pulse, ok);
        m_write(a, d, s, eresp, epulse);
        check("rnd_bvalid", ok, 1);
        check("rnd_bresp", resp, eresp);
        check("rnd_pulse", pulse, epulse);
        check("rnd_reg_out", reg_out, m_flat());
      end else begin
        axi_read(a, $urandom_range(0, 3), data, resp, ok);
        m_read(a, edata, eresp);
        check("rnd_rvalid", ok, 1);
        check("rnd_rresp", resp, eresp);
        check("rnd_rdata", data, edata);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
